// File: rtl/view_param_ctrl_rpt.sv
// Frame-synchronous Mandelbrot view controller: synchronised push-buttons with
// per-button press/auto-repeat, saturating zoom-scaled pan, and an update strobe.
module view_param_ctrl_rpt #(
    parameter int COORD_WIDTH   = 11,
    parameter int ZOOM_WIDTH    = 4,
    parameter int MAX_ZOOM      = 15,
    parameter int BASE_PAN_STEP = 32,
    parameter int DEFAULT_CX    = -128,
    parameter int DEFAULT_CY    = 0,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_RATE   = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          v_begin,
    input  logic [6:0]                    btn_in,
    output logic signed [COORD_WIDTH-1:0] centre_x,
    output logic signed [COORD_WIDTH-1:0] centre_y,
    output logic [ZOOM_WIDTH-1:0]         zoom_level,
    output logic                          param_update
);

    localparam int unsigned NBTN    = 7;
    localparam int unsigned SW      = COORD_WIDTH + 1;
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam int unsigned B_ZIN  = 0;
    localparam int unsigned B_ZOUT = 1;
    localparam int unsigned B_LEFT = 2;
    localparam int unsigned B_RGHT = 3;
    localparam int unsigned B_UP   = 4;
    localparam int unsigned B_DOWN = 5;
    localparam int unsigned B_HOME = 6;

    localparam logic signed [SW-1:0] C_MAX = SW'((1 << (COORD_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] C_MIN = SW'(-(1 << (COORD_WIDTH - 1)));
    localparam logic signed [COORD_WIDTH-1:0] DEF_CX = COORD_WIDTH'(DEFAULT_CX);
    localparam logic signed [COORD_WIDTH-1:0] DEF_CY = COORD_WIDTH'(DEFAULT_CY);
    localparam logic [ZOOM_WIDTH-1:0] ZMAX = ZOOM_WIDTH'(MAX_ZOOM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [NBTN-1:0]  r_sync [SYNC_STAGES];
    logic [NBTN-1:0]  w_btn;
    rpt_state_t       r_state     [NBTN];
    rpt_state_t       w_state_nxt [NBTN];
    logic [CNT_W-1:0] r_cnt       [NBTN];
    logic [CNT_W-1:0] w_cnt_nxt   [NBTN];
    logic [NBTN-1:0]  w_fire;

    logic signed [COORD_WIDTH-1:0] r_cx, r_cy, w_cx_nxt, w_cy_nxt;
    logic [ZOOM_WIDTH-1:0]         r_zoom, w_zoom_nxt;
    logic                          r_upd;
    logic [31:0]                   w_step_raw;
    logic signed [SW-1:0]          w_step;

    // Clamp a widened pan result back into the coordinate range.
    function automatic logic signed [COORD_WIDTH-1:0] sat_coord(input logic signed [SW-1:0] v);
        if (v > C_MAX)      return C_MAX[COORD_WIDTH-1:0];
        else if (v < C_MIN) return C_MIN[COORD_WIDTH-1:0];
        else                return v[COORD_WIDTH-1:0];
    endfunction

    // Button synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= btn_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_btn = r_sync[SYNC_STAGES-1];

    // Repeat FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NBTN; b++) begin
                r_state[b] <= ST_IDLE;
                r_cnt[b]   <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NBTN; b++) begin
                r_state[b] <= w_state_nxt[b];
                r_cnt[b]   <= w_cnt_nxt[b];
            end
        end
    end

    // Repeat FSM next state and fire decode; only advances on v_begin.
    always_comb begin
        w_fire = '0;
        for (int unsigned b = 0; b < NBTN; b++) begin
            w_state_nxt[b] = r_state[b];
            w_cnt_nxt[b]   = r_cnt[b];
            if (v_begin) begin
                case (r_state[b])
                    ST_IDLE: begin
                        if (w_btn[b]) begin
                            w_fire[b]      = 1'b1;
                            w_state_nxt[b] = ST_DELAY;
                            w_cnt_nxt[b]   = CNT_W'(1);
                        end
                    end
                    ST_DELAY: begin
                        if (!w_btn[b]) begin
                            w_state_nxt[b] = ST_IDLE;
                        end else if (r_cnt[b] == CNT_W'(REPEAT_DELAY)) begin
                            w_fire[b]      = 1'b1;
                            w_state_nxt[b] = ST_REPEAT;
                            w_cnt_nxt[b]   = CNT_W'(1);
                        end else begin
                            w_cnt_nxt[b]   = r_cnt[b] + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!w_btn[b]) begin
                            w_state_nxt[b] = ST_IDLE;
                        end else if (r_cnt[b] == CNT_W'(REPEAT_RATE)) begin
                            w_fire[b]      = 1'b1;
                            w_cnt_nxt[b]   = CNT_W'(1);
                        end else begin
                            w_cnt_nxt[b]   = r_cnt[b] + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt[b] = ST_IDLE;
                        w_cnt_nxt[b]   = '0;
                    end
                endcase
            end
        end
    end

    // View update from this frame's fires; pan step uses the pre-update zoom.
    always_comb begin
        w_step_raw = 32'(BASE_PAN_STEP) >> r_zoom;
        w_step     = (w_step_raw == 32'd0) ? SW'(1) : SW'(w_step_raw);
        w_zoom_nxt = r_zoom;
        w_cx_nxt   = r_cx;
        w_cy_nxt   = r_cy;
        if (w_fire[B_HOME]) begin
            w_zoom_nxt = '0;
            w_cx_nxt   = DEF_CX;
            w_cy_nxt   = DEF_CY;
        end else begin
            if (w_fire[B_ZIN] && !w_fire[B_ZOUT] && (r_zoom != ZMAX))
                w_zoom_nxt = r_zoom + ZOOM_WIDTH'(1);
            else if (w_fire[B_ZOUT] && !w_fire[B_ZIN] && (r_zoom != '0))
                w_zoom_nxt = r_zoom - ZOOM_WIDTH'(1);
            if (w_fire[B_LEFT] && !w_fire[B_RGHT])
                w_cx_nxt = sat_coord($signed({r_cx[COORD_WIDTH-1], r_cx}) - w_step);
            else if (w_fire[B_RGHT] && !w_fire[B_LEFT])
                w_cx_nxt = sat_coord($signed({r_cx[COORD_WIDTH-1], r_cx}) + w_step);
            if (w_fire[B_UP] && !w_fire[B_DOWN])
                w_cy_nxt = sat_coord($signed({r_cy[COORD_WIDTH-1], r_cy}) - w_step);
            else if (w_fire[B_DOWN] && !w_fire[B_UP])
                w_cy_nxt = sat_coord($signed({r_cy[COORD_WIDTH-1], r_cy}) + w_step);
        end
    end

    // Output registers and change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx   <= DEF_CX;
            r_cy   <= DEF_CY;
            r_zoom <= '0;
            r_upd  <= 1'b0;
        end else begin
            r_cx   <= w_cx_nxt;
            r_cy   <= w_cy_nxt;
            r_zoom <= w_zoom_nxt;
            r_upd  <= (w_cx_nxt != r_cx) || (w_cy_nxt != r_cy) || (w_zoom_nxt != r_zoom);
        end
    end

    assign centre_x     = r_cx;
    assign centre_y     = r_cy;
    assign zoom_level   = r_zoom;
    assign param_update = r_upd;

endmodule

// File: tb/tb_view_param_ctrl_rpt.sv
// Randomised and directed bench for view_param_ctrl_rpt against a frame-level model.
module tb_view_param_ctrl_rpt;

    localparam int RD = 16;
    localparam int RR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              v_begin;
    logic [6:0]        btn_in;
    logic signed [10:0] centre_x;
    logic signed [10:0] centre_y;
    logic [3:0]        zoom_level;
    logic              param_update;

    int n_total = 0;
    int n_pass  = 0;

    // Model: per-button held-frame count (-1 = released) and view values.
    int m_hold [7];
    int m_cx, m_cy, m_zoom;
    logic m_upd;
    int pulses;

    view_param_ctrl_rpt dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .v_begin      (v_begin),
        .btn_in       (btn_in),
        .centre_x     (centre_x),
        .centre_y     (centre_y),
        .zoom_level   (zoom_level),
        .param_update (param_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit fires(input int n);
        return (n == 0) || (n == RD) || (n > RD && ((n - RD) % RR) == 0);
    endfunction

    function automatic int clampc(input int v);
        if (v > 1023)  return 1023;
        if (v < -1024) return -1024;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_hold[i] = -1;
        m_cx = -128; m_cy = 0; m_zoom = 0; m_upd = 1'b0;
    endtask

    task automatic model_frame(input logic [6:0] b);
        bit f [7];
        int nx, ny, nz, step;
        for (int i = 0; i < 7; i++) begin
            if (b[i]) m_hold[i] = (m_hold[i] < 0) ? 0 : m_hold[i] + 1;
            else      m_hold[i] = -1;
            f[i] = b[i] && fires(m_hold[i]);
        end
        step = 32 >> m_zoom;
        if (step < 1) step = 1;
        nx = m_cx; ny = m_cy; nz = m_zoom;
        if (f[6]) begin
            nx = -128; ny = 0; nz = 0;
        end else begin
            if (f[0] && !f[1]) nz = (m_zoom < 15) ? m_zoom + 1 : 15;
            if (f[1] && !f[0]) nz = (m_zoom > 0) ? m_zoom - 1 : 0;
            if (f[2] && !f[3]) nx = clampc(m_cx - step);
            if (f[3] && !f[2]) nx = clampc(m_cx + step);
            if (f[4] && !f[5]) ny = clampc(m_cy - step);
            if (f[5] && !f[4]) ny = clampc(m_cy + step);
        end
        m_upd = (nx != m_cx) || (ny != m_cy) || (nz != m_zoom);
        m_cx = nx; m_cy = ny; m_zoom = nz;
    endtask

    task automatic frame(input logic [6:0] b);
        @(negedge clk);
        btn_in = b;
        repeat (4) @(negedge clk);
        v_begin = 1'b1;
        model_frame(b);
        @(posedge clk); #1;
        check("cx", centre_x, m_cx);
        check("cy", centre_y, m_cy);
        check("zoom", 32'(zoom_level), m_zoom);
        check("upd", 32'(param_update), 32'(m_upd));
        if (param_update) pulses++;
        @(negedge clk);
        v_begin = 1'b0;
        @(posedge clk); #1;
        check("upd_low", 32'(param_update), 0);
    endtask

    initial begin
        logic [6:0] b;
        rst_n = 1'b0; v_begin = 1'b0; btn_in = '0;
        model_reset();
        #22;
        check("rst_cx", centre_x, -128);
        check("rst_cy", centre_y, 0);
        check("rst_zoom", 32'(zoom_level), 0);
        check("rst_upd", 32'(param_update), 0);
        @(negedge clk); rst_n = 1'b1;

        // Idle frames after reset.
        pulses = 0;
        repeat (3) frame(7'h00);
        check("idle_pulses", pulses, 0);

        // Held zoom_in: fires on frames 0, 16, 20.
        pulses = 0;
        for (int i = 0; i < 24; i++) frame(7'h01);
        frame(7'h00);
        check("hold_zoom", 32'(zoom_level), 3);
        check("hold_pulses", pulses, 3);

        // Zoom to the top, then a one-LSB pan.
        frame(7'h40);
        for (int i = 0; i < 72; i++) frame(7'h01);
        frame(7'h00);
        check("zmax", 32'(zoom_level), 15);
        frame(7'h08);
        frame(7'h00);
        check("pan_z15", centre_x, -127);

        // Home, then a coarse left pan.
        frame(7'h40);
        frame(7'h00);
        frame(7'h04);
        frame(7'h00);
        check("pan_z0", centre_x, -160);

        // Hold right until saturation; further repeats give no strobe.
        for (int i = 0; i < 180; i++) frame(7'h08);
        frame(7'h00);
        check("sat_cx", centre_x, 1023);

        // Conflicting pans cancel while zoom still applies; home overrides.
        frame(7'h0D);
        frame(7'h00);
        frame(7'h61);
        frame(7'h00);
        check("home_cy", centre_y, 0);

        // Hold up into REPEAT, then asynchronous reset between edges.
        for (int i = 0; i < 22; i++) frame(7'h10);
        check("up_cy", centre_y, -96);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_cx", centre_x, -128);
        check("arst_cy", centre_y, 0);
        check("arst_zoom", 32'(zoom_level), 0);
        @(negedge clk); rst_n = 1'b1;
        frame(7'h10);
        check("arst_refire", centre_y, -32);
        frame(7'h00);

        // A 1-clk button glitch between frames is never sampled.
        @(negedge clk); btn_in = 7'h08;
        @(negedge clk); btn_in = 7'h00;
        repeat (8) @(negedge clk);
        frame(7'h00);
        check("glitch_cx", centre_x, -128);

        // Randomised holds and combinations, home only occasionally.
        b = '0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(3) == 0) begin
                b = 7'($urandom());
                if ($urandom_range(7) != 0) b[6] = 1'b0;
            end
            frame(b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
